// File: rtl/depth_pixel_scan_if.sv
// Pixel-stream and point-stream bundle between the upstream depth source,
// the scanner, and the back-projection stage.
interface depth_pixel_scan_if #(
    parameter int H_BW     = 10,
    parameter int V_BW     = 10,
    parameter int DEPTH_BW = 16,
    parameter int CNT_BW   = 20
);
    logic                i_start;
    logic                i_pix_valid;
    logic [DEPTH_BW-1:0] i_depth;
    logic [H_BW-1:0]     r_width;
    logic [V_BW-1:0]     r_height;
    logic [DEPTH_BW-1:0] r_depth_min;
    logic [DEPTH_BW-1:0] r_depth_max;
    logic [1:0]          r_stride_log2;

    logic                o_valid;
    logic [H_BW-1:0]     o_idx_x;
    logic [V_BW-1:0]     o_idx_y;
    logic [DEPTH_BW-1:0] o_depth;
    logic                o_busy;
    logic                o_frame_done;
    logic [CNT_BW-1:0]   o_point_cnt;

    modport master (
        output i_start, i_pix_valid, i_depth,
        output r_width, r_height, r_depth_min, r_depth_max, r_stride_log2,
        input  o_valid, o_idx_x, o_idx_y, o_depth, o_busy, o_frame_done, o_point_cnt
    );

    modport slave (
        input  i_start, i_pix_valid, i_depth,
        input  r_width, r_height, r_depth_min, r_depth_max, r_stride_log2,
        output o_valid, o_idx_x, o_idx_y, o_depth, o_busy, o_frame_done, o_point_cnt
    );
endinterface

// File: rtl/depth_pixel_scan.sv
// Raster scanner for one depth frame: tracks (x, y), filters by depth range and
// subsampling grid, and forwards surviving pixels with a 1-cycle registered latency.
module depth_pixel_scan #(
    parameter int H_BW     = 10,
    parameter int V_BW     = 10,
    parameter int DEPTH_BW = 16,
    parameter int CNT_BW   = 20
) (
    input logic               i_clk,
    input logic               i_rst_n,
    depth_pixel_scan_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t              state, state_next;
    logic [H_BW-1:0]     x, width_q;
    logic [V_BW-1:0]     y, height_q;
    logic [DEPTH_BW-1:0] min_q, max_q;
    logic [1:0]          stride_q;
    logic [3:0]          stride_mask;
    logic                take_start, take_pix, last_x, last_pix, pass;

    assign last_x      = (x == width_q - H_BW'(1));
    assign last_pix    = last_x && (y == height_q - V_BW'(1));
    assign stride_mask = 4'((4'd1 << stride_q) - 4'd1);
    assign pass        = (bus.i_depth != '0)
                      && (bus.i_depth >= min_q) && (bus.i_depth <= max_q)
                      && ((x & H_BW'(stride_mask)) == '0)
                      && ((y & V_BW'(stride_mask)) == '0);

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        take_start = 1'b0;
        take_pix   = 1'b0;
        case (state)
            // DONE accepts a start so back-to-back frames lose no cycle.
            IDLE, DONE: begin
                state_next = IDLE;
                if (bus.i_start) begin
                    take_start = 1'b1;
                    state_next = SCAN;
                end
            end
            SCAN: begin
                if (bus.i_pix_valid) begin
                    take_pix = 1'b1;
                    if (last_pix) state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_next;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            x                <= '0;
            y                <= '0;
            width_q          <= '0;
            height_q         <= '0;
            min_q            <= '0;
            max_q            <= '0;
            stride_q         <= '0;
            bus.o_valid      <= 1'b0;
            bus.o_idx_x      <= '0;
            bus.o_idx_y      <= '0;
            bus.o_depth      <= '0;
            bus.o_busy       <= 1'b0;
            bus.o_frame_done <= 1'b0;
            bus.o_point_cnt  <= '0;
        end else begin
            bus.o_valid      <= take_pix && pass;
            bus.o_busy       <= (state_next == SCAN);
            bus.o_frame_done <= (state_next == DONE);

            if (take_start) begin
                width_q         <= bus.r_width;
                height_q        <= bus.r_height;
                min_q           <= bus.r_depth_min;
                max_q           <= bus.r_depth_max;
                stride_q        <= bus.r_stride_log2;
                x               <= '0;
                y               <= '0;
                bus.o_point_cnt <= '0;
            end

            if (take_pix) begin
                if (pass) begin
                    bus.o_idx_x <= x;
                    bus.o_idx_y <= y;
                    bus.o_depth <= bus.i_depth;
                    if (bus.o_point_cnt != '1) bus.o_point_cnt <= bus.o_point_cnt + CNT_BW'(1);
                end
                if (last_x) begin
                    x <= '0;
                    y <= y + V_BW'(1);
                end else begin
                    x <= x + H_BW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_depth_pixel_scan.sv
// Scoreboard bench for depth_pixel_scan: directed frames push expected points and
// frame-done events; a negedge monitor pops and compares them.
module tb_depth_pixel_scan;
    localparam int H_BW = 10, V_BW = 10, DEPTH_BW = 16, CNT_BW = 20;

    typedef struct {int x; int y; int d; int cyc;} pt_t;
    typedef struct {int cnt; int cyc;} fd_t;

    logic i_clk = 1'b0;
    logic i_rst_n;
    int   cyc = 0;
    int   n_total = 0, n_pass = 0;
    pt_t  exp_pts[$];
    fd_t  exp_fd[$];

    depth_pixel_scan_if #(.H_BW(H_BW), .V_BW(V_BW), .DEPTH_BW(DEPTH_BW), .CNT_BW(CNT_BW)) bus ();

    depth_pixel_scan #(.H_BW(H_BW), .V_BW(V_BW), .DEPTH_BW(DEPTH_BW), .CNT_BW(CNT_BW)) u_dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus)
    );

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    always @(negedge i_clk) begin : monitor
        pt_t p;
        fd_t f;
        if (bus.o_valid) begin
            if (exp_pts.size() == 0) check("unexpected_point", 1, 0);
            else begin
                p = exp_pts.pop_front();
                check("pt_x", bus.o_idx_x, p.x);
                check("pt_y", bus.o_idx_y, p.y);
                check("pt_depth", bus.o_depth, p.d);
                check("pt_cycle", cyc, p.cyc);
            end
        end
        if (bus.o_frame_done) begin
            if (exp_fd.size() == 0) check("unexpected_frame_done", 1, 0);
            else begin
                f = exp_fd.pop_front();
                check("fd_point_cnt", bus.o_point_cnt, f.cnt);
                check("fd_cycle", cyc, f.cyc);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic start_frame(input int w, input int h, input int mn, input int mx,
                               input int st, input bit with_pix);
        bus.r_width       = H_BW'(w);
        bus.r_height      = V_BW'(h);
        bus.r_depth_min   = DEPTH_BW'(mn);
        bus.r_depth_max   = DEPTH_BW'(mx);
        bus.r_stride_log2 = 2'(st);
        bus.i_start       = 1'b1;
        bus.i_pix_valid   = with_pix;
        bus.i_depth       = 16'd999;
        tick(1);
        bus.i_start       = 1'b0;
        bus.i_pix_valid   = 1'b0;
    endtask

    task automatic pix(input int d, input bit emit, input int ex, input int ey,
                       input bit last, input int cnt);
        bus.i_pix_valid = 1'b1;
        bus.i_depth     = DEPTH_BW'(d);
        if (emit) exp_pts.push_back('{x: ex, y: ey, d: d, cyc: cyc + 1});
        if (last) exp_fd.push_back('{cnt: cnt, cyc: cyc + 1});
        tick(1);
        bus.i_pix_valid = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: bench did not complete within time limit");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        i_rst_n           = 1'b0;
        bus.i_start       = 1'b0;
        bus.i_pix_valid   = 1'b0;
        bus.i_depth       = '0;
        bus.r_width       = '0;
        bus.r_height      = '0;
        bus.r_depth_min   = '0;
        bus.r_depth_max   = '0;
        bus.r_stride_log2 = '0;
        tick(2);
        check("rst_valid", bus.o_valid, 0);
        check("rst_busy", bus.o_busy, 0);
        check("rst_frame_done", bus.o_frame_done, 0);
        check("rst_point_cnt", bus.o_point_cnt, 0);
        check("rst_idx_x", bus.o_idx_x, 0);
        check("rst_depth", bus.o_depth, 0);
        i_rst_n = 1'b1;
        tick(1);

        // Pixels in IDLE are ignored.
        bus.i_pix_valid = 1'b1;
        bus.i_depth     = 16'd5;
        tick(2);
        bus.i_pix_valid = 1'b0;

        // Full pass: 4x3, every depth in range.
        start_frame(4, 3, 1, 16'hFFFF, 0, 1'b0);
        check("busy_after_start", bus.o_busy, 1);
        for (int i = 0; i < 12; i++) pix(i + 1, 1'b1, i % 4, i / 4, i == 11, 12);
        check("busy_after_last", bus.o_busy, 0);
        tick(3);
        check("cnt_hold_idle", bus.o_point_cnt, 12);

        // Range filter: only 100 and 200 survive.
        start_frame(5, 1, 100, 200, 0, 1'b0);
        pix(0,   1'b0, 0, 0, 1'b0, 0);
        pix(99,  1'b0, 1, 0, 1'b0, 0);
        pix(100, 1'b1, 2, 0, 1'b0, 0);
        pix(200, 1'b1, 3, 0, 1'b0, 0);
        pix(201, 1'b0, 4, 0, 1'b1, 2);
        tick(1);

        // min > max: nothing emitted, frame still completes.
        start_frame(2, 1, 10, 5, 0, 1'b0);
        pix(7, 1'b0, 0, 0, 1'b0, 0);
        pix(7, 1'b0, 1, 0, 1'b1, 0);
        tick(1);

        // Stride 2 on an 8x4 frame: 8 points, last at (6,2).
        start_frame(8, 4, 1, 16'hFFFF, 1, 1'b0);
        for (int i = 0; i < 32; i++)
            pix(i + 1, ((i % 8) % 2 == 0) && ((i / 8) % 2 == 0), i % 8, i / 8, i == 31, 8);
        tick(1);

        // Stalls plus mid-frame register change: original 3x2 geometry holds.
        start_frame(3, 2, 1, 16'hFFFF, 0, 1'b0);
        pix(11, 1'b1, 0, 0, 1'b0, 0);
        tick(2);
        pix(12, 1'b1, 1, 0, 1'b0, 0);
        bus.r_width  = 10'd7;
        bus.r_height = 10'd9;
        pix(13, 1'b1, 2, 0, 1'b0, 0);
        tick(2);
        pix(14, 1'b1, 0, 1, 1'b0, 0);
        pix(15, 1'b1, 1, 1, 1'b0, 0);
        tick(1);
        pix(16, 1'b1, 2, 1, 1'b1, 6);

        // Start during SCAN ignored; start on the frame_done cycle accepted.
        start_frame(2, 2, 1, 16'hFFFF, 0, 1'b0);
        pix(1, 1'b1, 0, 0, 1'b0, 0);
        bus.i_start = 1'b1;
        tick(1);
        bus.i_start = 1'b0;
        check("busy_ignored_start", bus.o_busy, 1);
        pix(2, 1'b1, 1, 0, 1'b0, 0);
        pix(3, 1'b1, 0, 1, 1'b0, 0);
        pix(4, 1'b1, 1, 1, 1'b1, 4);
        start_frame(1, 2, 1, 16'hFFFF, 0, 1'b0);
        check("busy_restart_on_done", bus.o_busy, 1);
        check("cnt_cleared_on_restart", bus.o_point_cnt, 0);
        pix(5, 1'b1, 0, 0, 1'b0, 0);
        pix(6, 1'b1, 0, 1, 1'b1, 2);
        tick(1);

        // Reset after 5 pixels: outputs clear immediately, no frame_done.
        start_frame(4, 2, 1, 16'hFFFF, 0, 1'b0);
        for (int i = 0; i < 4; i++) pix(i + 1, 1'b1, i, 0, 1'b0, 0);
        pix(5, 1'b0, 0, 1, 1'b0, 0);
        i_rst_n = 1'b0;
        #1;
        check("midrst_valid", bus.o_valid, 0);
        check("midrst_idx_x", bus.o_idx_x, 0);
        check("midrst_idx_y", bus.o_idx_y, 0);
        check("midrst_depth", bus.o_depth, 0);
        check("midrst_busy", bus.o_busy, 0);
        check("midrst_point_cnt", bus.o_point_cnt, 0);
        tick(2);
        i_rst_n = 1'b1;
        tick(1);

        // Start with a coincident pixel: the pixel is dropped, scan begins at (0,0).
        start_frame(2, 1, 1, 16'hFFFF, 0, 1'b1);
        pix(7, 1'b1, 0, 0, 1'b0, 0);
        pix(8, 1'b1, 1, 0, 1'b1, 2);
        tick(3);

        check("points_drained", exp_pts.size(), 0);
        check("frame_done_drained", exp_fd.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
